// File: rtl/aes_decryption.sv
// rtl/aes_decryption.sv - iterative AES-128/192/256 block decryptor with on-chip key expansion
// Optional expanded-key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decryption (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [1:0]   mux,
  input  logic [127:0] in_state,
  output logic [127:0] out_state,
  output logic [3:0]   counter,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ARK, S_ROUND, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mux_q;
  logic [127:0]  in_q;
  logic [127:0]  st_q;
  logic [5:0]    wi_q;
  logic [2:0]    wj_q;
  logic [7:0]    rcon_q;
  logic [31:0]   w [0:59];

  logic [3:0]    nk, nr, rm1;
  logic [5:0]    last_w;
  logic [31:0]   temp, kx, new_w;
  logic [127:0]  rk_ark, rk_rnd, round_out;
  logic          start_ok, cache_hit, load_key;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, built from the squares a^2..a^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, p;
    sq = a;
    p  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  // Returns {9a, 11a, 13a, 14a} from a single xtime chain.
  function automatic logic [31:0] inv_mults(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [31:0] m0, m1, m2, m3;
    m0 = inv_mults(col[31:24]);
    m1 = inv_mults(col[23:16]);
    m2 = inv_mults(col[15:8]);
    m3 = inv_mults(col[7:0]);
    return {m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24],
            m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0]};
  endfunction

  // Byte b = row + 4*col sits at [127-8b -: 8]; row r is rotated right by r.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r)&3)) -: 8]);
    t = t ^ rk;
    if (mix)
      for (int c = 0; c < 4; c++)
        t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    return t;
  endfunction

  assign nk       = 4'd4 + {1'b0, mux_q, 1'b0};
  assign nr       = 4'd10 + {1'b0, mux_q, 1'b0};
  assign last_w   = {nr, 2'b11};
  assign rm1      = counter - 4'd1;
  assign start_ok = start && (mux != 2'b11);
  assign load_key = (state_q == S_IDLE) && start_ok && !cache_hit;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  assign rk_ark = {w[{nr, 2'd0}], w[{nr, 2'd1}], w[{nr, 2'd2}], w[{nr, 2'd3}]};
  assign rk_rnd = {w[{rm1, 2'd0}], w[{rm1, 2'd1}], w[{rm1, 2'd2}], w[{rm1, 2'd3}]};
  assign round_out = inv_round(st_q, rk_rnd, counter != 4'd1);

`ifdef AES_DEC_KEY_CACHE_EN
  logic [255:0] key_c;
  logic         valid_q;

  assign cache_hit = valid_q && (key == key_c) && (mux == mux_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_c   <= '0;
      valid_q <= 1'b0;
    end else if (load_key) begin
      key_c   <= key;
      valid_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      valid_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // wj_q tracks i mod Nk so no divider is needed.
  always_comb begin
    temp = w[wi_q - 6'd1];
    kx   = temp;
    if (wj_q == 3'd0)
      kx = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h0};
    else if ((mux_q == 2'b10) && (wj_q == 3'd4))
      kx = sub_word(temp);
    new_w = w[wi_q - {2'b00, nk}] ^ kx;
  end

  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int k = 0; k < 8; k++) w[k] <= key[255-32*k -: 32];
    end else if (state_q == S_KEXP) begin
      w[wi_q] <= new_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = cache_hit ? S_ARK : S_KEXP;
      S_KEXP:  if (wi_q == last_w) state_d = S_ARK;
      S_ARK:   state_d = S_ROUND;
      S_ROUND: if (counter == 4'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mux_q     <= 2'b00;
      in_q      <= '0;
      st_q      <= '0;
      wi_q      <= '0;
      wj_q      <= '0;
      rcon_q    <= 8'h01;
      counter   <= '0;
      out_state <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          counter <= '0;
          if (start_ok) begin
            mux_q  <= mux;
            in_q   <= in_state;
            wi_q   <= {2'b00, 4'd4 + {1'b0, mux, 1'b0}};
            wj_q   <= '0;
            rcon_q <= 8'h01;
          end
        end
        S_KEXP: begin
          wi_q <= wi_q + 6'd1;
          wj_q <= ({1'b0, wj_q} == nk - 4'd1) ? 3'd0 : wj_q + 3'd1;
          if (wj_q == 3'd0) rcon_q <= xtime(rcon_q);
        end
        S_ARK: begin
          st_q    <= in_q ^ rk_ark;
          counter <= nr;
        end
        S_ROUND: begin
          st_q    <= round_out;
          counter <= counter - 4'd1;
          if (counter == 4'd1) out_state <= round_out;
        end
        S_DONE:  counter <= '0;
        default: counter <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decryption.sv
// tb/tb_aes_decryption.sv - self-checking bench for aes_decryption against a reference AES model
module tb_aes_decryption;

  logic         clk, reset, start;
  logic [255:0] key;
  logic [1:0]   mux;
  logic [127:0] in_state, out_state;
  logic [3:0]   counter;
  logic         busy, done;

  aes_decryption dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .mux(mux), .in_state(in_state),
    .out_state(out_state), .counter(counter), .busy(busy), .done(done)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [255:0] k, input logic [1:0] m,
                                               input logic [127:0] ct);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [127:0] res;
    nk = 4 + 2 * int'(m);
    nr = 10 + 2 * int'(m);
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*nr+4; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ w[4*nr + b/4][31-8*(b%4) -: 8];
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) u[r + 4*((c+r)%4)] = s[r + 4*c];
      for (int b = 0; b < 16; b++) s[b] = isb[u[b]] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
          s[4*c+1] = gmul(a0, 9)  ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
          s[4*c+2] = gmul(a0, 13) ^ gmul(a1, 9)  ^ gmul(a2, 14) ^ gmul(a3, 11);
          s[4*c+3] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9)  ^ gmul(a3, 14);
        end
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // Cycle-level model: job timeline is K expansion cycles, one ARK, Nr rounds, one DONE.
  bit           m_act = 0;
  int           m_e = 0, m_k = 0, m_nr = 0;
  logic [127:0] m_res = '0, m_out = '0;
  bit           c_valid = 0;
  logic [255:0] c_key = '0, j_key = '0;
  logic [1:0]   c_mux = '0, j_mux = '0;

  always @(posedge clk) begin
    bit hit;
    if (!reset) begin
      m_act = 0; m_out = '0; c_valid = 0;
    end else if (m_act) begin
      m_e++;
      if (m_e == m_k + m_nr + 1) begin
        m_out = m_res; c_valid = 1; c_key = j_key; c_mux = j_mux;
      end else if (m_e > m_k + m_nr + 1) begin
        m_act = 0;
      end
    end else if (start && mux != 2'b11) begin
      m_nr = 10 + 2 * int'(mux);
      hit  = CACHE && c_valid && key == c_key && mux == c_mux;
      m_k  = hit ? 0 : 4 * (m_nr + 1) - (4 + 2 * int'(mux));
      if (!hit) c_valid = 0;
      j_key = key; j_mux = mux;
      m_res = ref_decrypt(key, mux, in_state);
      m_act = 1; m_e = 0;
    end
  end

  always @(negedge clk) begin
    bit e_done;
    int e_cnt;
    e_done = m_act && m_e == m_k + m_nr + 1;
    e_cnt  = (m_act && m_e >= m_k + 1 && m_e <= m_k + m_nr) ? m_nr - (m_e - m_k - 1) : 0;
    if (!reset) begin
      chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_counter", counter, 0); chk("rst_out", out_state, 0);
    end else begin
      chk("busy", busy, m_act); chk("done", done, e_done);
      chk("counter", counter, e_cnt); chk("out_state", out_state, m_out);
    end
  end

  task automatic run_job(input logic [255:0] k, input logic [1:0] m, input logic [127:0] ct,
                         output int lat, output int maxc);
    @(negedge clk);
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    key = k; mux = m; in_state = ct; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = -1; maxc = 0;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(negedge clk);
      if (int'(counter) > maxc) maxc = int'(counter);
      if (done) lat = n;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat, mc, ndone;
    build_tables();
    reset = 1'b0; start = 1'b0; key = '0; mux = '0; in_state = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", out_state, 0);
    chk("reset_counter", counter, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("model_sbox_00", sb[8'h00], 8'h63);
    chk("model_sbox_53", sb[8'h53], 8'hed);
    chk("model_isbox_63", isb[8'h63], 8'h00);
    chk("model_128", ref_decrypt(K128, 2'b00, CT128), PT);
    chk("model_192", ref_decrypt(K192, 2'b01, CT192), PT);
    chk("model_256", ref_decrypt(K256, 2'b10, CT256), PT);
    @(posedge clk); #2 reset = 1'b1;

    run_job(K128, 2'b00, CT128, lat, mc);
    chk("lat_128", lat, 51); chk("out_128", out_state, PT);
    run_job(K192, 2'b01, CT192, lat, mc);
    chk("lat_192", lat, 59); chk("out_192", out_state, PT);
    run_job(K256, 2'b10, CT256, lat, mc);
    chk("lat_256", lat, 67); chk("out_256", out_state, PT); chk("maxcnt_256", mc, 14);

    @(negedge clk); key = K128; mux = 2'b11; in_state = CT128; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      chk("rsv_busy", busy, 0); chk("rsv_done", done, 0);
      @(negedge clk);
    end

    key = K256; mux = 2'b10; in_state = CT256; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    key = ~K256; in_state = CT128; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int n = 0; n < 80; n++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("busy_start_ndone", ndone, 1); chk("busy_start_out", out_state, PT);

    key = K128; mux = 2'b00; in_state = CT128; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 200 && counter != 4'd7; n++) @(negedge clk);
    chk("abort_cnt7", counter, 7);
    #1 reset = 1'b0;
    #1;
    chk("abort_out", out_state, 0); chk("abort_counter", counter, 0);
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    run_job(K128, 2'b00, CT128, lat, mc);
    chk("lat_after_rst", lat, 51); chk("out_after_rst", out_state, PT);

    run_job(K256, 2'b10, CT256, lat, mc);
    chk("lat_c1", lat, 67);
    run_job(K256, 2'b10, CT256, lat, mc);
    chk("lat_c2", lat, CACHE ? 15 : 67); chk("out_c2", out_state, PT);
    run_job(K256 ^ 256'h1, 2'b10, CT256, lat, mc);
    chk("lat_c3", lat, 67); chk("out_c3_differs", out_state == PT, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
